// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: RV32I load/store width codes and FSM states.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned IDX_W  = 30;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } lsu_funct3_t;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts/extends sub-word loads and merges sub-word store data
// into a previously read memory word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merge_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata[{byte_off, 3'b000} +: 8];
    assign rd_half = rdata[{byte_off[1], 4'b0000} +: 16];

    always_comb begin
        load_data  = '0;
        merge_data = rdata;
        case (funct3)
            F3_B: begin
                load_data = {{24{rd_byte[7]}}, rd_byte};
                merge_data[{byte_off, 3'b000} +: 8] = wdata[7:0];
            end
            F3_H: begin
                load_data = {{16{rd_half[15]}}, rd_half};
                merge_data[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            F3_W: begin
                load_data  = rdata;
                merge_data = wdata;
            end
            F3_BU:   load_data = {24'h0, rd_byte};
            F3_HU:   load_data = {16'h0, rd_half};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-only Data_Mem; SB/SH are done as a
// stalled two-cycle read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic [31:0] lsu_rdata,
    output logic        lsu_stall,
    output logic        lsu_fault,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t      state_q;
    logic [XLEN-1:0] merge_q;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merge_data;
    logic [IDX_W-1:0] word_idx;
    logic            bad_access;
    logic            out_of_range;
    logic            fault_c;
    logic            sub_store;

    assign word_idx     = lsu_addr[31:2];
    assign out_of_range = word_idx >= IDX_W'(MEM_WORDS);
    assign sub_store    = lsu_we && (lsu_funct3 == F3_B || lsu_funct3 == F3_H);

    // Misalignment and illegal width/direction combinations
    always_comb begin
        bad_access = 1'b0;
        case (lsu_funct3)
            F3_B:    bad_access = 1'b0;
            F3_H:    bad_access = lsu_addr[0];
            F3_W:    bad_access = lsu_addr[1:0] != 2'b00;
            F3_BU:   bad_access = lsu_we;
            F3_HU:   bad_access = lsu_we || lsu_addr[0];
            default: bad_access = 1'b1;
        endcase
    end

    assign fault_c = lsu_req && (state_q == IDLE) && (bad_access || out_of_range);

    lsu_lane_align u_lane_align (
        .funct3     (lsu_funct3),
        .byte_off   (lsu_addr[1:0]),
        .rdata      (mem_rdata),
        .wdata      (lsu_wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            merge_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lsu_req && !fault_c && sub_store) begin
                        merge_q <= merge_data;
                        state_q <= RMW_WR;
                    end
                end
                RMW_WR:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory port and core-facing outputs; everything held low while in reset
    always_comb begin
        lsu_rdata = '0;
        lsu_stall = 1'b0;
        lsu_fault = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            mem_addr = {2'b00, word_idx};
            case (state_q)
                IDLE: begin
                    if (lsu_req) begin
                        if (fault_c) begin
                            lsu_fault = 1'b1;
                        end else if (!lsu_we) begin
                            mem_rd_en = 1'b1;
                            lsu_rdata = load_data;
                        end else if (sub_store) begin
                            mem_rd_en = 1'b1;
                            lsu_stall = 1'b1;
                        end else begin
                            mem_wr_en = 1'b1;
                            mem_wdata = lsu_wdata;
                        end
                    end
                end
                RMW_WR: begin
                    mem_wr_en = 1'b1;
                    mem_wdata = merge_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 32-word behavioural Data_Mem
// (word 0 discards writes).
module tb_load_store_unit;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_req;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_stall;
    logic        lsu_fault;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [32];
    logic        pre_we;
    logic [4:0]  pre_idx;
    logic [31:0] pre_data;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.MEM_WORDS(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .lsu_req    (lsu_req),
        .lsu_we     (lsu_we),
        .lsu_funct3 (lsu_funct3),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_rdata  (lsu_rdata),
        .lsu_stall  (lsu_stall),
        .lsu_fault  (lsu_fault),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_idx] <= pre_data;
        else if (mem_wr_en && mem_addr < 32 && mem_addr != 0)
            mem[mem_addr[4:0]] <= mem_wdata;
    end

    always_comb mem_rdata = (mem_addr < 32) ? mem[mem_addr[4:0]] : 32'h0;

    task automatic drive(input logic req, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        lsu_req = req; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
    endtask

    task automatic preload(input logic [4:0] idx, input logic [31:0] data);
        @(negedge clk);
        drive(1'b0, 1'b0, W, 32'h0, 32'h0);
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic test_reset;
        preload(5'd3, 32'hCAFEF00D);
        @(negedge clk);
        drive(1'b1, 1'b1, W, 32'h0C, 32'h12345678);
        #1;
        checks++;
        if ({lsu_rdata, lsu_stall, lsu_fault, mem_rd_en, mem_wr_en, mem_addr, mem_wdata} !== 100'h0) begin
            errors++;
            $display("FAIL reset_sw_outputs: wr=%b rd=%b addr=%h wdata=%h rdata=%h, all zero required",
                     mem_wr_en, mem_rd_en, mem_addr, mem_wdata, lsu_rdata);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, B, 32'h0C, 32'h0);
        #1;
        checks++;
        if ({lsu_rdata, mem_rd_en, lsu_fault} !== 34'h0) begin
            errors++;
            $display("FAIL reset_lb_outputs: rd=%b rdata=%h fault=%b, all zero required", mem_rd_en, lsu_rdata, lsu_fault);
        end
        checks++;
        if (mem[3] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL reset_no_write: got %h expected cafef00d", mem[3]);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, W, 32'h0, 32'h0);
    endtask

    task automatic test_store_load_word;
        @(negedge clk);
        drive(1'b1, 1'b1, W, 32'h08, 32'hDEADBEEF);
        #1;
        checks++;
        if ({mem_wr_en, mem_rd_en, lsu_stall, mem_addr, mem_wdata, lsu_rdata} !== {3'b100, 32'd2, 32'hDEADBEEF, 32'h0}) begin
            errors++;
            $display("FAIL sw_port: wr=%b rd=%b stall=%b addr=%h wdata=%h rdata=%h, required wr=1 rd=0 stall=0 addr=2 wdata=deadbeef rdata=0",
                     mem_wr_en, mem_rd_en, lsu_stall, mem_addr, mem_wdata, lsu_rdata);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, W, 32'h08, 32'h0);
        #1;
        checks++;
        if (mem[2] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_mem_word2: got %h expected deadbeef", mem[2]);
        end
        checks++;
        if ({mem_rd_en, mem_wr_en, lsu_stall, lsu_rdata} !== {3'b100, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL lw_readback: rd=%b wr=%b stall=%b rdata=%h, required rd=1 wr=0 stall=0 rdata=deadbeef",
                     mem_rd_en, mem_wr_en, lsu_stall, lsu_rdata);
        end
    endtask

    task automatic test_sub_word_load;
        logic [2:0]  f3  [6] = '{B, BU, H, HU, H, B};
        logic [31:0] ad  [6] = '{32'h0B, 32'h0B, 32'h0A, 32'h0A, 32'h08, 32'h0A};
        logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                                 32'h000080FF, 32'h00000000, 32'hFFFFFFFF};
        preload(5'd2, 32'h80FF0000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, f3[i], ad[i], 32'h0);
            #1;
            checks++;
            if (lsu_rdata !== exp[i] || lsu_stall !== 1'b0 || mem_rd_en !== 1'b1) begin
                errors++;
                $display("FAIL subword_load[%0d]: rdata=%h stall=%b rd=%b, required rdata=%h stall=0 rd=1",
                         i, lsu_rdata, lsu_stall, mem_rd_en, exp[i]);
            end
        end
    endtask

    task automatic test_rmw_byte;
        preload(5'd2, 32'h11223344);
        @(negedge clk);
        drive(1'b1, 1'b1, B, 32'h09, 32'h000000AA);
        #1;
        checks++;
        if ({lsu_stall, mem_rd_en, mem_wr_en, lsu_rdata} !== {3'b110, 32'h0}) begin
            errors++;
            $display("FAIL sb_cycle1: stall=%b rd=%b wr=%b rdata=%h, required stall=1 rd=1 wr=0 rdata=0",
                     lsu_stall, mem_rd_en, mem_wr_en, lsu_rdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({lsu_stall, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, lsu_rdata} !== {3'b001, 32'd2, 32'h1122AA44, 32'h0}) begin
            errors++;
            $display("FAIL sb_cycle2: stall=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h, required wr=1 addr=2 wdata=1122aa44",
                     lsu_stall, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, lsu_rdata);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, W, 32'h0, 32'h0);
        checks++;
        if (mem[2] !== 32'h1122AA44) begin
            errors++;
            $display("FAIL sb_mem: got %h expected 1122aa44", mem[2]);
        end
    endtask

    task automatic test_rmw_commit_no_req;
        preload(5'd4, 32'hA1B2C3D4);
        @(negedge clk);
        drive(1'b1, 1'b1, B, 32'h10, 32'hFFFFFF5A);
        #1;
        checks++;
        if (lsu_stall !== 1'b1) begin
            errors++;
            $display("FAIL sb_noreq_stall: got %b expected 1", lsu_stall);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, W, 32'h10, 32'h0);
        #1;
        checks++;
        if ({mem_wr_en, mem_addr, mem_wdata, lsu_stall} !== {1'b1, 32'd4, 32'hA1B2C35A, 1'b0}) begin
            errors++;
            $display("FAIL sb_commit_noreq: wr=%b addr=%h wdata=%h stall=%b, required wr=1 addr=4 wdata=a1b2c35a stall=0",
                     mem_wr_en, mem_addr, mem_wdata, lsu_stall);
        end
        @(negedge clk);
        checks++;
        if (mem[4] !== 32'hA1B2C35A) begin
            errors++;
            $display("FAIL sb_noreq_mem: got %h expected a1b2c35a", mem[4]);
        end
    endtask

    task automatic test_faults;
        logic        we [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3 [6] = '{H, W, W, 3'b011, BU, HU};
        logic [31:0] ad [6] = '{32'h05, 32'h06, 32'h80, 32'h10, 32'h10, 32'h13};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1'b1, we[i], f3[i], ad[i], 32'h12345678);
            #1;
            checks++;
            if ({lsu_fault, mem_rd_en, mem_wr_en, lsu_stall, lsu_rdata} !== {4'b1000, 32'h0}) begin
                errors++;
                $display("FAIL fault[%0d]: fault=%b rd=%b wr=%b stall=%b rdata=%h, required fault=1 others 0",
                         i, lsu_fault, mem_rd_en, mem_wr_en, lsu_stall, lsu_rdata);
            end
        end
        @(negedge clk);
        drive(1'b0, 1'b0, W, 32'h05, 32'h0);
        #1;
        checks++;
        if ({lsu_fault, mem_rd_en, mem_wr_en} !== 3'b000) begin
            errors++;
            $display("FAIL fault_no_req: fault=%b rd=%b wr=%b, required 0", lsu_fault, mem_rd_en, mem_wr_en);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, W, 32'h7C, 32'h0);
        #1;
        checks++;
        if ({lsu_fault, mem_rd_en, mem_addr} !== {2'b01, 32'd31}) begin
            errors++;
            $display("FAIL last_word_ok: fault=%b rd=%b addr=%h, required fault=0 rd=1 addr=1f", lsu_fault, mem_rd_en, mem_addr);
        end
        @(negedge clk);
        drive(1'b1, 1'b1, W, 32'h00, 32'h55AA55AA);
        #1;
        checks++;
        if ({lsu_fault, mem_wr_en, mem_addr, mem_wdata} !== {2'b01, 32'd0, 32'h55AA55AA}) begin
            errors++;
            $display("FAIL word0_store_issued: fault=%b wr=%b addr=%h wdata=%h, required fault=0 wr=1 addr=0 wdata=55aa55aa",
                     lsu_fault, mem_wr_en, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_reset_in_rmw;
        preload(5'd3, 32'h55667788);
        @(negedge clk);
        drive(1'b1, 1'b1, H, 32'h0C, 32'h00001234);
        #1;
        checks++;
        if (lsu_stall !== 1'b1) begin
            errors++;
            $display("FAIL sh_rst_stall: got %b expected 1", lsu_stall);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_wr_en, lsu_stall} !== 2'b00) begin
            errors++;
            $display("FAIL rmw_reset_drop: wr=%b stall=%b, required 0 0", mem_wr_en, lsu_stall);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, W, 32'h0C, 32'h0);
        #1;
        checks++;
        if ({lsu_stall, mem_wr_en, mem_rd_en, lsu_rdata} !== {3'b001, 32'h55667788}) begin
            errors++;
            $display("FAIL rmw_reset_idle: stall=%b wr=%b rd=%b rdata=%h, required stall=0 wr=0 rd=1 rdata=55667788",
                     lsu_stall, mem_wr_en, mem_rd_en, lsu_rdata);
        end
    endtask

    task automatic test_back_to_back;
        preload(5'd3, 32'h00001111);
        @(negedge clk);
        drive(1'b1, 1'b1, H, 32'h0E, 32'h0000BEEF);
        #1;
        checks++;
        if ({lsu_stall, mem_rd_en, mem_wr_en} !== 3'b110) begin
            errors++;
            $display("FAIL sh_cycle1: stall=%b rd=%b wr=%b, required 1 1 0", lsu_stall, mem_rd_en, mem_wr_en);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({mem_wr_en, mem_addr, mem_wdata, lsu_stall} !== {1'b1, 32'd3, 32'hBEEF1111, 1'b0}) begin
            errors++;
            $display("FAIL sh_cycle2: wr=%b addr=%h wdata=%h stall=%b, required wr=1 addr=3 wdata=beef1111 stall=0",
                     mem_wr_en, mem_addr, mem_wdata, lsu_stall);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, W, 32'h0C, 32'h0);
        #1;
        checks++;
        if ({lsu_stall, mem_rd_en, mem_wr_en, lsu_rdata} !== {3'b010, 32'hBEEF1111}) begin
            errors++;
            $display("FAIL b2b_lw: stall=%b rd=%b wr=%b rdata=%h, required stall=0 rd=1 wr=0 rdata=beef1111",
                     lsu_stall, mem_rd_en, mem_wr_en, lsu_rdata);
        end
    endtask

    initial begin
        reset  = 1'b1;
        pre_we = 1'b0; pre_idx = '0; pre_data = '0;
        drive(1'b0, 1'b0, W, 32'h0, 32'h0);
        test_reset;
        test_store_load_word;
        test_sub_word_load;
        test_rmw_byte;
        test_rmw_commit_no_req;
        test_faults;
        test_reset_in_rmw;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
